// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, handles stalls, EX redirects and flush bubbles.
// Optional feature macro FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_stalled/perf_flushed counters.
module fetch_stage #(
  parameter int          ADDR_BITS   = 8,
  parameter int          RESET_PC    = 0,
  parameter int          FLUSH_SLOTS = 1,
  parameter logic [31:0] NOP_INST    = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus1,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled,
  output logic [31:0] perf_flushed,
`endif
  output logic        if_valid
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [ADDR_BITS-1:0] ONE        = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] PC_INIT    = ADDR_BITS'(RESET_PC);
  localparam logic [1:0]           FLUSH_INIT = 2'(FLUSH_SLOTS - 1);

  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [31:0]          ifInst_q, ifInst_d;
  logic [ADDR_BITS-1:0] ifPc_q, ifPc_d;
  logic [ADDR_BITS-1:0] ifPcPlus1_q, ifPcPlus1_d;
  logic                 ifValid_q, ifValid_d;
  logic [0:0]           state_q, state_d;
  logic [1:0]           flushCnt_q, flushCnt_d;
  logic                 doFetch, doStall, doBubble;

  always_comb begin
    pc_d        = pc_q;
    ifInst_d    = ifInst_q;
    ifPc_d      = ifPc_q;
    ifPcPlus1_d = ifPcPlus1_q;
    ifValid_d   = ifValid_q;
    state_d     = state_q;
    flushCnt_d  = flushCnt_q;
    doFetch     = 1'b0;
    doStall     = 1'b0;
    doBubble    = 1'b0;
    if (branch_taken) begin
      pc_d        = branch_target[ADDR_BITS-1:0];
      ifInst_d    = NOP_INST;
      ifPc_d      = '0;
      ifPcPlus1_d = '0;
      ifValid_d   = 1'b0;
      flushCnt_d  = FLUSH_INIT;
      state_d     = (FLUSH_INIT != 2'd0) ? FLUSH : RUN;
      doBubble    = 1'b1;
    end else if (stall) begin
      doStall = 1'b1;
    end else if (state_q == RUN) begin
      ifInst_d    = inst_in;
      ifPc_d      = pc_q;
      ifPcPlus1_d = pc_q + ONE;
      ifValid_d   = 1'b1;
      pc_d        = pc_q + ONE;
      doFetch     = 1'b1;
    end else begin
      // Prefetch keeps advancing while bubbles drain; the last bubble returns to RUN.
      ifInst_d    = NOP_INST;
      ifPc_d      = '0;
      ifPcPlus1_d = '0;
      ifValid_d   = 1'b0;
      pc_d        = pc_q + ONE;
      flushCnt_d  = flushCnt_q - 2'd1;
      state_d     = (flushCnt_q == 2'd1) ? RUN : FLUSH;
      doBubble    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= PC_INIT;
      ifInst_q    <= NOP_INST;
      ifPc_q      <= '0;
      ifPcPlus1_q <= '0;
      ifValid_q   <= 1'b0;
      state_q     <= RUN;
      flushCnt_q  <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      ifInst_q    <= ifInst_d;
      ifPc_q      <= ifPc_d;
      ifPcPlus1_q <= ifPcPlus1_d;
      ifValid_q   <= ifValid_d;
      state_q     <= state_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign pc_out      = {{(32-ADDR_BITS){1'b0}}, pc_q};
  assign if_inst     = ifInst_q;
  assign if_pc       = {{(32-ADDR_BITS){1'b0}}, ifPc_q};
  assign if_pc_plus1 = {{(32-ADDR_BITS){1'b0}}, ifPcPlus1_q};
  assign if_valid    = ifValid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetched_q, perfStalled_q, perfFlushed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perfFetched_q <= '0;
      perfStalled_q <= '0;
      perfFlushed_q <= '0;
    end else begin
      if (doFetch && perfFetched_q != 32'hFFFFFFFF) perfFetched_q <= perfFetched_q + 32'd1;
      if (doStall && perfStalled_q != 32'hFFFFFFFF) perfStalled_q <= perfStalled_q + 32'd1;
      if (doBubble && perfFlushed_q != 32'hFFFFFFFF) perfFlushed_q <= perfFlushed_q + 32'd1;
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_stalled = perfStalled_q;
  assign perf_flushed = perfFlushed_q;
`else
  logic unusedPerf;
  assign unusedPerf = doFetch ^ doStall ^ doBubble ^ (|branch_target[31:ADDR_BITS]);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one DUT with a single flush slot, one with three.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset1, stall1, br1;
  logic [31:0] tgt1, inst1, pc1, ifInst1, ifPc1, ifPcP1_1;
  logic        valid1;
  logic        reset3, stall3, br3;
  logic [31:0] tgt3, inst3, pc3, ifInst3, ifPc3, ifPcP1_3;
  logic        valid3;
  int          total = 0;
  int          bad = 0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf1, ps1, pfl1, pf3, ps3, pfl3;
`endif

  always #5 clock = ~clock;

  // Instruction memory contents are a recognisable function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE0000 | (a & 32'h000000FF);
  endfunction

  assign inst1 = memWord(pc1);
  assign inst3 = memWord(pc3);

  fetch_stage #(.ADDR_BITS(8), .RESET_PC(0), .FLUSH_SLOTS(1), .NOP_INST(32'h0)) dut1 (
    .clock(clock), .reset(reset1), .stall(stall1), .branch_taken(br1),
    .branch_target(tgt1), .inst_in(inst1), .pc_out(pc1), .if_inst(ifInst1),
    .if_pc(ifPc1), .if_pc_plus1(ifPcP1_1),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(pf1), .perf_stalled(ps1), .perf_flushed(pfl1),
`endif
    .if_valid(valid1));

  fetch_stage #(.ADDR_BITS(8), .RESET_PC(0), .FLUSH_SLOTS(3), .NOP_INST(32'h0)) dut3 (
    .clock(clock), .reset(reset3), .stall(stall3), .branch_taken(br3),
    .branch_target(tgt3), .inst_in(inst3), .pc_out(pc3), .if_inst(ifInst3),
    .if_pc(ifPc3), .if_pc_plus1(ifPcP1_3),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(pf3), .perf_stalled(ps3), .perf_flushed(pfl3),
`endif
    .if_valid(valid3));

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDut1(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] ipc, input logic [31:0] ipc1, input logic v);
    checkOutput({tag, ".pc_out"}, pc1, pc);
    checkOutput({tag, ".if_inst"}, ifInst1, inst);
    checkOutput({tag, ".if_pc"}, ifPc1, ipc);
    checkOutput({tag, ".if_pc_plus1"}, ifPcP1_1, ipc1);
    checkOutput({tag, ".if_valid"}, {31'd0, valid1}, {31'd0, v});
  endtask

  task automatic checkDut3(input string tag, input logic [31:0] pc, input logic [31:0] ipc, input logic v);
    checkOutput({tag, ".pc_out"}, pc3, pc);
    checkOutput({tag, ".if_pc"}, ifPc3, ipc);
    checkOutput({tag, ".if_valid"}, {31'd0, valid3}, {31'd0, v});
  endtask

  initial begin
    reset1 = 1'b1; stall1 = 1'b0; br1 = 1'b0; tgt1 = 32'd0;
    reset3 = 1'b1; stall3 = 1'b0; br3 = 1'b0; tgt3 = 32'd0;
    applyStimulus();
    checkDut1("reset", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    checkDut3("reset3", 32'd0, 32'd0, 1'b0);

    reset1 = 1'b0; reset3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus();
      checkDut1($sformatf("run%0d", k), k, memWord(k - 1), k - 1, k, 1'b1);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_fetched", pf1, 32'd4);
`endif

    applyStimulus();
    checkDut1("run5", 32'd5, memWord(4), 32'd4, 32'd5, 1'b1);

    stall1 = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      applyStimulus();
      checkDut1($sformatf("stall%0d", k), 32'd5, memWord(4), 32'd4, 32'd5, 1'b1);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_stalled", ps1, 32'd2);
`endif
    stall1 = 1'b0;
    applyStimulus();
    checkDut1("resume", 32'd6, memWord(5), 32'd5, 32'd6, 1'b1);

    br1 = 1'b1; tgt1 = 32'h00000108;
    applyStimulus();
    checkDut1("branch8", 32'd8, 32'd0, 32'd0, 32'd0, 1'b0);
    br1 = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_flushed", pfl1, 32'd1);
`endif
    applyStimulus();
    checkDut1("after8", 32'd9, memWord(8), 32'd8, 32'd9, 1'b1);

    br1 = 1'b1; stall1 = 1'b1; tgt1 = 32'd10;
    applyStimulus();
    checkDut1("brstall", 32'd10, 32'd0, 32'd0, 32'd0, 1'b0);
    br1 = 1'b0; stall1 = 1'b0;
    applyStimulus();
    checkDut1("after10", 32'd11, memWord(10), 32'd10, 32'd11, 1'b1);

    br1 = 1'b1; tgt1 = 32'd255;
    applyStimulus();
    checkDut1("to255", 32'd255, 32'd0, 32'd0, 32'd0, 1'b0);
    br1 = 1'b0;
    applyStimulus();
    checkDut1("wrap", 32'd0, memWord(255), 32'd255, 32'd0, 1'b1);

    br3 = 1'b1; tgt3 = 32'd20;
    applyStimulus();
    checkDut3("fl_b1", 32'd20, 32'd0, 1'b0);
    br3 = 1'b0;
    applyStimulus();
    checkDut3("fl_b2", 32'd21, 32'd0, 1'b0);
    stall3 = 1'b1;
    applyStimulus();
    checkDut3("fl_stall", 32'd21, 32'd0, 1'b0);
    stall3 = 1'b0;
    applyStimulus();
    checkDut3("fl_b3", 32'd22, 32'd0, 1'b0);
    applyStimulus();
    checkDut3("fl_first", 32'd23, 32'd22, 1'b1);
    checkOutput("fl_first.if_inst", ifInst3, memWord(22));

    br3 = 1'b1; tgt3 = 32'd40;
    applyStimulus();
    br3 = 1'b0;
    applyStimulus();
    checkDut3("fl40", 32'd41, 32'd0, 1'b0);
    reset3 = 1'b1;
    applyStimulus();
    checkDut3("flreset", 32'd0, 32'd0, 1'b0);
    reset3 = 1'b0;
    applyStimulus();
    checkDut3("postreset", 32'd1, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
